// File: rtl/task_pkg.sv
// Shared definitions for the task output path: answer-channel arbiter sizing,
// its state encoding and a small round-robin index helper.
package task_pkg;

    localparam int ANSWER_ARB_N_TASKS = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_RELEASE
    } answer_arb_state_t;

    // Index reached by stepping `off` places past `base` in a ring of `n` slots.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/task_answer_arbiter_if.sv
// Answer-channel bundle between the task output blocks, the manager and the arbiter.
// The slave modport is the arbiter's view; master is the task/manager side.
interface task_answer_arbiter_if
    import task_pkg::*;
#(
    parameter int N_TASKS = ANSWER_ARB_N_TASKS,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 12
);

    logic [N_TASKS-1:0]          i_tanswer_ready;
    logic [N_TASKS*DATA_W-1:0]   i_tdata;
    logic [N_TASKS-1:0]          i_tanswer_data_last;
    logic [N_TASKS*SIZE_W-1:0]   i_packet_size_in_bytes;
    logic [N_TASKS-1:0]          o_tmanager_ready;
    logic                        i_manager_ready;
    logic                        o_tanswer_ready;
    logic [DATA_W-1:0]           o_tdata;
    logic                        o_tanswer_data_last;
    logic [SIZE_W-1:0]           o_packet_size_in_bytes;
    logic [$clog2(N_TASKS)-1:0]  o_grant_id;
    logic                        o_busy;
    logic                        o_len_err;

    modport slave (
        input  i_tanswer_ready,
        input  i_tdata,
        input  i_tanswer_data_last,
        input  i_packet_size_in_bytes,
        input  i_manager_ready,
        output o_tmanager_ready,
        output o_tanswer_ready,
        output o_tdata,
        output o_tanswer_data_last,
        output o_packet_size_in_bytes,
        output o_grant_id,
        output o_busy,
        output o_len_err
    );

    modport master (
        output i_tanswer_ready,
        output i_tdata,
        output i_tanswer_data_last,
        output i_packet_size_in_bytes,
        output i_manager_ready,
        input  o_tmanager_ready,
        input  o_tanswer_ready,
        input  o_tdata,
        input  o_tanswer_data_last,
        input  o_packet_size_in_bytes,
        input  o_grant_id,
        input  o_busy,
        input  o_len_err
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after the last
// grant, wrapping around; reusable by any shared-channel arbiter.
module rr_priority_picker
    import task_pkg::*;
#(
    parameter int N = ANSWER_ARB_N_TASKS
) (
    input  logic [N-1:0]          i_req,
    input  logic [$clog2(N)-1:0]  i_last_grant,
    output logic                  o_found,
    output logic [$clog2(N)-1:0]  o_winner
);

    localparam int IDW = $clog2(N);

    logic [IDW-1:0] idx;

    // Scan from the far end so the nearest requester after last_grant is written last.
    always_comb begin
        o_found  = |i_req;
        o_winner = '0;
        idx      = '0;
        for (int off = N; off >= 1; off--) begin
            idx = IDW'(rr_wrap(int'(i_last_grant), off, N));
            if (i_req[idx]) begin
                o_winner = idx;
            end
        end
    end

endmodule

// File: rtl/task_answer_arbiter.sv
// Round-robin arbiter sharing the manager answer channel between task output
// blocks; a grant is held until the owning packet ends or is aborted.
module task_answer_arbiter
    import task_pkg::*;
#(
    parameter int N_TASKS = ANSWER_ARB_N_TASKS,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    task_answer_arbiter_if.slave  bus
);

    localparam int                IDW       = $clog2(N_TASKS);
    localparam logic [IDW-1:0]    LAST_INIT = IDW'(N_TASKS - 1);
    localparam logic [SIZE_W:0]   ONE_EXT   = (SIZE_W + 1)'(1);
    localparam logic [SIZE_W-1:0] ONE       = SIZE_W'(1);

    answer_arb_state_t state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic              len_err_q, len_err_d;

    logic              found;
    logic [IDW-1:0]    winner;
    logic [SIZE_W-1:0] win_size;
    logic              g_req;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic [SIZE_W:0]   cnt_plus;
    logic              size_mismatch;

    rr_priority_picker #(
        .N (N_TASKS)
    ) u_picker (
        .i_req        (bus.i_tanswer_ready),
        .i_last_grant (last_grant_q),
        .o_found      (found),
        .o_winner     (winner)
    );

    assign win_size      = bus.i_packet_size_in_bytes[int'(winner)*SIZE_W +: SIZE_W];
    assign g_req         = bus.i_tanswer_ready[grant_q];
    assign g_last        = bus.i_tanswer_data_last[grant_q];
    assign g_data        = bus.i_tdata[int'(grant_q)*DATA_W +: DATA_W];
    // Extra bit keeps a saturated counter from wrapping back onto a valid size.
    assign cnt_plus      = {1'b0, cnt_q} + ONE_EXT;
    assign size_mismatch = (cnt_plus != {1'b0, size_q});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
            size_q       <= '0;
            cnt_q        <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        size_d       = size_q;
        cnt_d        = cnt_q;
        len_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    size_d  = win_size;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                if (!g_req) begin
                    len_err_d = 1'b1;
                    state_d   = S_RELEASE;
                end else if (bus.i_manager_ready) begin
                    if (g_last) begin
                        len_err_d = size_mismatch;
                        state_d   = S_RELEASE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_RELEASE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [N_TASKS-1:0] tmanager_ready;
    logic               tanswer_ready;
    logic [DATA_W-1:0]  tdata;
    logic               tanswer_last;
    logic [SIZE_W-1:0]  size_out;

    always_comb begin
        tmanager_ready = '0;
        tanswer_ready  = 1'b0;
        tdata          = '0;
        tanswer_last   = 1'b0;
        size_out       = '0;
        if (state_q == S_XFER) begin
            tanswer_ready           = g_req;
            tdata                   = g_data;
            tanswer_last            = g_last;
            tmanager_ready[grant_q] = bus.i_manager_ready;
        end
        if (state_q == S_GRANT || state_q == S_XFER) begin
            size_out = size_q;
        end
    end

    assign bus.o_tmanager_ready       = tmanager_ready;
    assign bus.o_tanswer_ready        = tanswer_ready;
    assign bus.o_tdata                = tdata;
    assign bus.o_tanswer_data_last    = tanswer_last;
    assign bus.o_packet_size_in_bytes = size_out;
    assign bus.o_grant_id             = grant_q;
    assign bus.o_busy                 = (state_q != S_IDLE);
    assign bus.o_len_err              = len_err_q;

endmodule
